// File: rtl/bypass_network_tagged.sv
// Tag-matched operand bypass: each producer lane feeds a DEPTH-deep delay line and every
// consumer picks the youngest valid entry whose tag matches its source tag.
module bypass_network_tagged #(
   parameter int NUM_PROD         = 4,
   parameter int NUM_CONS         = 6,
   parameter int DEPTH            = 2,
   parameter int DATA_W           = 64,
   parameter int TAG_W            = 7,
   parameter int ZERO_TAG_NOMATCH = 1,
   localparam int LANE_W          = $clog2((NUM_PROD > 2) ? NUM_PROD : 2),
   localparam int STAGE_W         = $clog2((DEPTH > 2) ? DEPTH : 2)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         clear,
   input  logic [NUM_PROD-1:0]          prod_valid,
   input  logic [NUM_PROD*TAG_W-1:0]    prod_tag,
   input  logic [NUM_PROD*DATA_W-1:0]   prod_data,
   input  logic [NUM_CONS*TAG_W-1:0]    cons_tag,
   input  logic [NUM_CONS*DATA_W-1:0]   cons_rf_data,
   output logic [NUM_CONS*DATA_W-1:0]   cons_data,
   output logic [NUM_CONS-1:0]          cons_hit,
   output logic [NUM_CONS*LANE_W-1:0]   cons_src_lane,
   output logic [NUM_CONS*STAGE_W-1:0]  cons_src_stage
);

   logic              r_valid [NUM_PROD][DEPTH];
   logic [TAG_W-1:0]  r_tag   [NUM_PROD][DEPTH];
   logic [DATA_W-1:0] r_data  [NUM_PROD][DEPTH];

   // Data is captured even for invalid writes; only the valid bit gates matching.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int p = 0; p < NUM_PROD; p++) begin
            for (int s = 0; s < DEPTH; s++) begin
               r_valid[p][s] <= 1'b0;
               r_tag[p][s]   <= '0;
               r_data[p][s]  <= '0;
            end
         end
      end else if (!stall) begin
         for (int p = 0; p < NUM_PROD; p++) begin
            r_valid[p][0] <= prod_valid[p];
            r_tag[p][0]   <= prod_tag[p*TAG_W +: TAG_W];
            r_data[p][0]  <= prod_data[p*DATA_W +: DATA_W];
            for (int s = 1; s < DEPTH; s++) begin
               r_valid[p][s] <= r_valid[p][s-1];
               r_tag[p][s]   <= r_tag[p][s-1];
               r_data[p][s]  <= r_data[p][s-1];
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CONS; gi++) begin : g_cons
         logic [TAG_W-1:0]   w_tag;
         logic               w_tag_ok;
         logic               w_hit;
         logic [DATA_W-1:0]  w_data;
         logic [LANE_W-1:0]  w_lane;
         logic [STAGE_W-1:0] w_stage;

         assign w_tag    = cons_tag[gi*TAG_W +: TAG_W];
         assign w_tag_ok = !((ZERO_TAG_NOMATCH != 0) && (w_tag == '0));

         // Scan oldest-to-youngest, highest-to-lowest lane: the last match written wins,
         // which leaves the lowest stage and then the lowest lane in place.
         always_comb begin
            w_hit   = 1'b0;
            w_data  = cons_rf_data[gi*DATA_W +: DATA_W];
            w_lane  = '0;
            w_stage = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
               for (int p = NUM_PROD - 1; p >= 0; p--) begin
                  if (w_tag_ok && r_valid[p][s] && (r_tag[p][s] == w_tag)) begin
                     w_hit   = 1'b1;
                     w_data  = r_data[p][s];
                     w_lane  = LANE_W'(p);
                     w_stage = STAGE_W'(s);
                  end
               end
            end
         end

         assign cons_data[gi*DATA_W +: DATA_W]        = w_data;
         assign cons_hit[gi]                          = w_hit;
         assign cons_src_lane[gi*LANE_W +: LANE_W]    = w_lane;
         assign cons_src_stage[gi*STAGE_W +: STAGE_W] = w_stage;
      end
   endgenerate

endmodule

// File: tb/tb_bypass_network_tagged.sv
// Cycle-by-cycle vector table plus directed sequences for the tagged bypass network;
// a second instance with zero-tag matching enabled covers the hard-wired-zero option.
module tb_bypass_network_tagged;
   localparam int NP = 4;
   localparam int NC = 6;
   localparam int DW = 64;
   localparam int TW = 7;
   localparam int LW = 2;
   localparam int SW = 1;
   localparam int NV = 27;

   logic              clk = 1'b0;
   logic              rst, stall, clear;
   logic [NP-1:0]     prod_valid;
   logic [NP*TW-1:0]  prod_tag;
   logic [NP*DW-1:0]  prod_data;
   logic [NC*TW-1:0]  cons_tag;
   logic [NC*DW-1:0]  cons_rf_data;
   logic [NC*DW-1:0]  cons_data, z_data;
   logic [NC-1:0]     cons_hit, z_hit;
   logic [NC*LW-1:0]  cons_src_lane, z_lane;
   logic [NC*SW-1:0]  cons_src_stage, z_stage;

   always #5 clk = ~clk;

   bypass_network_tagged #(.NUM_PROD(NP), .NUM_CONS(NC), .DEPTH(2), .DATA_W(DW), .TAG_W(TW),
                           .ZERO_TAG_NOMATCH(1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .clear(clear),
      .prod_valid(prod_valid), .prod_tag(prod_tag), .prod_data(prod_data),
      .cons_tag(cons_tag), .cons_rf_data(cons_rf_data),
      .cons_data(cons_data), .cons_hit(cons_hit),
      .cons_src_lane(cons_src_lane), .cons_src_stage(cons_src_stage)
   );

   bypass_network_tagged #(.NUM_PROD(NP), .NUM_CONS(NC), .DEPTH(2), .DATA_W(DW), .TAG_W(TW),
                           .ZERO_TAG_NOMATCH(0)) dut_z (
      .clk(clk), .rst(rst), .stall(stall), .clear(clear),
      .prod_valid(prod_valid), .prod_tag(prod_tag), .prod_data(prod_data),
      .cons_tag(cons_tag), .cons_rf_data(cons_rf_data),
      .cons_data(z_data), .cons_hit(z_hit),
      .cons_src_lane(z_lane), .cons_src_stage(z_stage)
   );

   typedef struct {
      logic          st, cl;
      logic [3:0]    pv;
      logic [27:0]   pt;
      logic [255:0]  pd;
      logic [6:0]    ct;
      logic [63:0]   rf;
      logic          eh;
      logic [63:0]   ed;
      logic [1:0]    el;
      logic          es;
   } vec_t;

   typedef struct {
      logic [NC-1:0]         hit;
      logic [NC-1:0][DW-1:0] data;
      logic [NC-1:0][LW-1:0] lane;
      logic [NC-1:0]         stage;
      logic                  zchk;
      logic [NC-1:0]         zhit;
      logic [NC-1:0][DW-1:0] zdata;
      logic [NC-1:0][LW-1:0] zlane;
      logic [NC-1:0]         zstage;
   } exp_t;

   vec_t tbl [NV];
   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cur   = 0;
   logic [NC*TW-1:0] ct_flat;
   logic [NC*DW-1:0] rf_flat;
   exp_t             e_hand;

   function automatic vec_t V(input logic st, input logic cl, input logic [3:0] pv,
                              input logic [27:0] pt, input logic [255:0] pd, input logic [6:0] ct,
                              input logic [63:0] rf, input logic eh, input logic [63:0] ed,
                              input logic [1:0] el, input logic es);
      vec_t v;
      v.st = st; v.cl = cl; v.pv = pv; v.pt = pt; v.pd = pd; v.ct = ct; v.rf = rf;
      v.eh = eh; v.ed = ed; v.el = el; v.es = es;
      return v;
   endfunction

   function automatic exp_t uni(input logic eh, input logic [63:0] ed, input logic [1:0] el,
                                input logic es, input logic [NC*DW-1:0] rf);
      exp_t e;
      e.zchk = 1'b0; e.zhit = '0; e.zdata = '0; e.zlane = '0; e.zstage = '0;
      for (int c = 0; c < NC; c++) begin
         e.hit[c]   = eh;
         e.data[c]  = eh ? ed : rf[c*DW +: DW];
         e.lane[c]  = eh ? el : 2'd0;
         e.stage[c] = eh ? es : 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input int c, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s v%0d c%0d: got %0h want %0h", nm, cur, c, got, want);
      end
   endtask

   task automatic cyc(input logic r, input logic st, input logic cl, input logic [3:0] pv,
                      input logic [27:0] pt, input logic [255:0] pd, input logic [NC*TW-1:0] ct,
                      input logic [NC*DW-1:0] crf, input exp_t e);
      exp_t g;
      rst = r; stall = st; clear = cl;
      prod_valid = pv; prod_tag = pt; prod_data = pd;
      cons_tag = ct; cons_rf_data = crf;
      sb.push_back(e);
      #7;
      g = sb.pop_front();
      $display("vec %0d: hit=%b lane=%h stage=%b", cur, cons_hit, cons_src_lane, cons_src_stage);
      for (int c = 0; c < NC; c++) begin
         chk("hit",   c, 64'(cons_hit[c]),              64'(g.hit[c]));
         chk("data",  c, cons_data[c*DW +: DW],         g.data[c]);
         chk("lane",  c, 64'(cons_src_lane[c*LW +: LW]), 64'(g.lane[c]));
         chk("stage", c, 64'(cons_src_stage[c]),        64'(g.stage[c]));
         if (g.zchk) begin
            chk("z_hit",   c, 64'(z_hit[c]),              64'(g.zhit[c]));
            chk("z_data",  c, z_data[c*DW +: DW],         g.zdata[c]);
            chk("z_lane",  c, 64'(z_lane[c*LW +: LW]),    64'(g.zlane[c]));
            chk("z_stage", c, 64'(z_stage[c]),            64'(g.zstage[c]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Each row is one cycle; expectations describe outputs seen in that same cycle.
      tbl[0]  = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd5,  64'h1111, 0, 64'h0,    2'd0, 1'b0);
      tbl[1]  = V(0,0,4'b0001, {21'd0,7'd5},        {192'd0,64'hAAAA},                   7'd5,  64'h1111, 0, 64'h0,    2'd0, 1'b0);
      tbl[2]  = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd5,  64'h1111, 1, 64'hAAAA, 2'd0, 1'b0);
      tbl[3]  = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd5,  64'h1111, 1, 64'hAAAA, 2'd0, 1'b1);
      tbl[4]  = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd5,  64'h1111, 0, 64'h0,    2'd0, 1'b0);
      tbl[5]  = V(0,0,4'b0010, {14'd0,7'd9,7'd0},   {128'd0,64'h10,64'h0},               7'd9,  64'h990,  0, 64'h0,    2'd0, 1'b0);
      tbl[6]  = V(0,0,4'b0100, {7'd0,7'd9,14'd0},   {64'd0,64'h20,128'd0},               7'd9,  64'h990,  1, 64'h10,   2'd1, 1'b0);
      tbl[7]  = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd9,  64'h990,  1, 64'h20,   2'd2, 1'b0);
      tbl[8]  = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd9,  64'h990,  1, 64'h20,   2'd2, 1'b1);
      tbl[9]  = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd9,  64'h990,  0, 64'h0,    2'd0, 1'b0);
      tbl[10] = V(0,0,4'b1001, {7'd12,14'd0,7'd12}, {64'h40,128'd0,64'h30},              7'd12, 64'hC00,  0, 64'h0,    2'd0, 1'b0);
      tbl[11] = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd12, 64'hC00,  1, 64'h30,   2'd0, 1'b0);
      tbl[12] = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd12, 64'hC00,  1, 64'h30,   2'd0, 1'b1);
      tbl[13] = V(0,0,4'b0001, {21'd0,7'd7},        {192'd0,64'h55},                     7'd7,  64'h770,  0, 64'h0,    2'd0, 1'b0);
      tbl[14] = V(1,0,4'b0000, 28'd0,               256'd0,                              7'd7,  64'h770,  1, 64'h55,   2'd0, 1'b0);
      tbl[15] = V(1,0,4'b0000, 28'd0,               256'd0,                              7'd7,  64'h770,  1, 64'h55,   2'd0, 1'b0);
      tbl[16] = V(1,0,4'b0000, 28'd0,               256'd0,                              7'd7,  64'h770,  1, 64'h55,   2'd0, 1'b0);
      tbl[17] = V(0,1,4'b0001, {21'd0,7'd8},        {192'd0,64'h88},                     7'd7,  64'h770,  1, 64'h55,   2'd0, 1'b0);
      tbl[18] = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd7,  64'h770,  0, 64'h0,    2'd0, 1'b0);
      tbl[19] = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd8,  64'h880,  0, 64'h0,    2'd0, 1'b0);
      tbl[20] = V(0,0,4'b0000, {21'd0,7'd4},        {192'd0,64'h44},                     7'd4,  64'h400,  0, 64'h0,    2'd0, 1'b0);
      tbl[21] = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd4,  64'h400,  0, 64'h0,    2'd0, 1'b0);
      tbl[22] = V(0,0,4'b0001, {21'd0,7'd4},        {192'd0,64'h4444},                   7'd4,  64'h400,  0, 64'h0,    2'd0, 1'b0);
      tbl[23] = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd4,  64'h400,  1, 64'h4444, 2'd0, 1'b0);
      tbl[24] = V(0,0,4'b1000, {7'd33,21'd0},       {64'hDEAD,192'd0},                   7'd33, 64'h330,  0, 64'h0,    2'd0, 1'b0);
      tbl[25] = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd33, 64'h330,  1, 64'hDEAD, 2'd3, 1'b0);
      tbl[26] = V(0,0,4'b0000, 28'd0,               256'd0,                              7'd33, 64'h330,  1, 64'hDEAD, 2'd3, 1'b1);

      rst = 1'b1; stall = 1'b0; clear = 1'b0;
      prod_valid = '0; prod_tag = '0; prod_data = '0; cons_tag = '0; cons_rf_data = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         cur = i;
         ct_flat = {NC{tbl[i].ct}};
         for (int c = 0; c < NC; c++) rf_flat[c*DW +: DW] = tbl[i].rf + 64'(c);
         cyc(1'b0, tbl[i].st, tbl[i].cl, tbl[i].pv, tbl[i].pt, tbl[i].pd, ct_flat, rf_flat,
             uni(tbl[i].eh, tbl[i].ed, tbl[i].el, tbl[i].es, rf_flat));
      end

      // Zero tag: ignored by the main instance, matched by the instance with the option off.
      cur = 100;
      ct_flat = '0; rf_flat = '0;
      e_hand = uni(1'b0, 64'h0, 2'd0, 1'b0, rf_flat);
      e_hand.zchk = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 4'b0001, {21'd0,7'd0}, {192'd0,64'hFF}, ct_flat, rf_flat, e_hand);
      cur = 101;
      e_hand = uni(1'b0, 64'h0, 2'd0, 1'b0, rf_flat);
      e_hand.zchk = 1'b1;
      for (int c = 0; c < NC; c++) begin
         e_hand.zhit[c] = 1'b1; e_hand.zdata[c] = 64'hFF;
      end
      cyc(1'b0, 1'b0, 1'b0, 4'b0000, 28'd0, 256'd0, ct_flat, rf_flat, e_hand);

      // Independent consumers looking up different tags in the same cycle.
      cur = 102;
      ct_flat = {NC{7'd22}};
      for (int c = 0; c < NC; c++) rf_flat[c*DW +: DW] = 64'h500 + 64'(c);
      cyc(1'b0, 1'b0, 1'b0, 4'b0011, {14'd0,7'd21,7'd20}, {128'd0,64'h210,64'h200}, ct_flat, rf_flat,
          uni(1'b0, 64'h0, 2'd0, 1'b0, rf_flat));
      cur = 103;
      ct_flat = {7'd0, 7'd20, 7'd21, 7'd22, 7'd21, 7'd20};
      e_hand = uni(1'b0, 64'h0, 2'd0, 1'b0, rf_flat);
      e_hand.hit[0] = 1'b1; e_hand.data[0] = 64'h200; e_hand.lane[0] = 2'd0;
      e_hand.hit[1] = 1'b1; e_hand.data[1] = 64'h210; e_hand.lane[1] = 2'd1;
      e_hand.hit[3] = 1'b1; e_hand.data[3] = 64'h210; e_hand.lane[3] = 2'd1;
      e_hand.hit[4] = 1'b1; e_hand.data[4] = 64'h200; e_hand.lane[4] = 2'd0;
      cyc(1'b0, 1'b0, 1'b0, 4'b0000, 28'd0, 256'd0, ct_flat, rf_flat, e_hand);

      // Reset mid-stream drops an in-flight result that would otherwise still be at stage 1.
      cur = 104;
      ct_flat = {NC{7'd30}};
      for (int c = 0; c < NC; c++) rf_flat[c*DW +: DW] = 64'h3000 + 64'(c);
      cyc(1'b0, 1'b0, 1'b0, 4'b0100, {7'd0,7'd30,14'd0}, {64'd0,64'h300,128'd0}, ct_flat, rf_flat,
          uni(1'b0, 64'h0, 2'd0, 1'b0, rf_flat));
      cur = 105;
      cyc(1'b1, 1'b0, 1'b0, 4'b0000, 28'd0, 256'd0, ct_flat, rf_flat,
          uni(1'b1, 64'h300, 2'd2, 1'b0, rf_flat));
      cur = 106;
      cyc(1'b0, 1'b0, 1'b0, 4'b0000, 28'd0, 256'd0, ct_flat, rf_flat,
          uni(1'b0, 64'h0, 2'd0, 1'b0, rf_flat));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/bypass_network_tagged.md
Name: bypass_network_tagged

Overview:
- Parametrised, tag-matched successor to the fixed-select bypass network.
- Each producer lane writes its result into a DEPTH-deep delay line of registered stages.
- Each consumer port searches all live stages for a valid entry whose physical-register tag matches its source tag; the youngest match wins, otherwise register-file read data passes through.
- Sits between the register-read stage and the execution units of every issue pipe; the scheduler no longer has to precompute stage/lane select codes.

Parameters:
- NUM_PROD, 4, number of producer lanes (int, complex, mem, fp combined).
- NUM_CONS, 6, number of consumer operand ports.
- DEPTH, 2, registered stages per producer lane (EX, WB, ...); must be ≥1.
- DATA_W, 64, operand data width.
- TAG_W, 7, physical register tag width.
- ZERO_TAG_NOMATCH, 1, when 1 a tag of value 0 never matches (hard-wired zero register).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  backend stall; all stages hold.
- clear  in  1  backend flush; all stages invalidated.
- prod_valid  in  NUM_PROD  producer result valid this cycle.
- prod_tag  in  NUM_PROD*TAG_W  destination tag per producer.
- prod_data  in  NUM_PROD*DATA_W  result data per producer.
- cons_tag  in  NUM_CONS*TAG_W  source tag per consumer.
- cons_rf_data  in  NUM_CONS*DATA_W  register-file read data per consumer.
- cons_data  out  NUM_CONS*DATA_W  selected operand.
- cons_hit  out  NUM_CONS  1 = bypassed, 0 = register-file data used.
- cons_src_lane  out  NUM_CONS*clog2(max(NUM_PROD,2))  winning producer index (0 when no hit).
- cons_src_stage  out  NUM_CONS*clog2(max(DEPTH,2))  winning stage index (0 when no hit).

Behaviour:
- Storage: entry[p][s] = {valid, tag, data} for p < NUM_PROD, s < DEPTH.
- Update priority: rst > clear > stall > shift.
  - rst or clear: all valid ← 0, tag ← 0, data ← 0.
  - stall (no rst/clear): every entry holds.
  - Shift: entry[p][0] ← {prod_valid[p], prod_tag[p], prod_data[p]}; entry[p][s] ← entry[p][s-1] for s ≥ 1; entry[p][DEPTH-1] content is dropped.
- Latency: a producer write in cycle N is visible to consumers from cycle N+1 (stage 0) through cycle N+DEPTH (stage DEPTH-1), assuming no stall; stalled cycles extend visibility 1:1.
- prod_data is captured even when prod_valid=0; a valid=0 entry never matches.
- Lookup is combinational from registered entries plus cons_tag/cons_rf_data. There is no same-cycle producer→consumer forwarding.
- Match condition: entry.valid && entry.tag == cons_tag && !(ZERO_TAG_NOMATCH && cons_tag == 0).
- Priority among multiple matches:
  - Lowest stage index wins (youngest result).
  - Ties within a stage go to the lowest producer index.
  - Duplicate matches are legal and must resolve deterministically.
- No hit: cons_data = cons_rf_data, cons_hit = 0, cons_src_lane = 0, cons_src_stage = 0.
- Reset outputs: all entries invalid, so cons_hit = 0 and cons_data = cons_rf_data for every consumer in the cycle after rst.
- Reset or clear mid-stream: all in-flight results are lost the next cycle. Inputs presented in the same cycle as clear are not captured.
- Consumer ports are independent; any number may hit the same entry in the same cycle.
- Widths are fully parametric. No assertion fires for DEPTH=1 or NUM_PROD=1; index outputs stay 1 bit wide.

Test Plan:
- Basic forwarding: reset; cycle 0 prod 0 valid, tag=5, data=0xAAAA; cons 0 tag=5, rf=0x1111 → cycle 1: cons_data=0xAAAA, hit=1, lane=0, stage=0; cycle 2: stage=1; cycle 3: data=0x1111, hit=0.
- Youngest wins: cycle 0 prod 1 tag=9 data=0x10; cycle 1 prod 2 tag=9 data=0x20 → cycle 2: cons tag 9 gets 0x20, lane=2, stage=0.
- Same-stage tie: cycle 0 prod 0 and prod 3 both tag=12, data 0x30 and 0x40 → cycle 1: data=0x30, lane=0.
- Stall/clear: write tag=7 data=0x55, then stall for 3 cycles → hit persists at stage 0 throughout. Then assert clear together with a new prod write tag=8 → next cycle: hit=0 for tags 7 and 8.
- Zero tag: prod writes tag=0 data=0xFF, cons tag=0, rf=0 → with ZERO_TAG_NOMATCH=1, hit=0 and data=0; with ZERO_TAG_NOMATCH=0, hit=1 and data=0xFF.
- Invalid entry and multi-consumer: prod_valid=0 with tag=4 gives no hit. Then a valid tag=4 write is read by all 6 consumers in the same cycle → all hit with identical data.
